// File: rtl/qbus_master.sv
// QBUS bus master: runs one DATI/DATO(B) cycle per request with an RPLY timeout.
// Strobes and the AD drive are decoded from the current state only.
module qbus_master #(
  parameter int TOUT = 64
) (
  input  logic        pin_clk_p,
  input  logic        pin_dclo_n,
  input  logic        req,
  input  logic        we,
  input  logic        bt,
  input  logic [15:0] adr,
  input  logic [15:0] wdat,
  output logic [15:0] rdat,
  output logic        ack,
  output logic        err,
  output logic        busy,
  input  logic [15:0] pin_ad_in_n,
  output logic [15:0] pin_ad_out_n,
  output logic        pin_ad_oe,
  output logic        pin_sync_n,
  output logic        pin_din_n,
  output logic        pin_dout_n,
  output logic        pin_wtbt_n,
  input  logic        pin_rply_n,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADR  = 3'd1,
    S_SYN  = 3'd2,
    S_DAT  = 3'd3,
    S_STB  = 3'd4,
    S_REL  = 3'd5,
    S_FIN  = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  localparam logic [7:0] TOUT_LAST = 8'(TOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] adr_q, adr_d;
  logic [15:0] wdat_q, wdat_d;
  logic        we_q, we_d;
  logic        bt_q, bt_d;
  logic [15:0] rdat_q, rdat_d;
  logic        rply_m_q, rply_s_q;

  always_ff @(posedge pin_clk_p) begin
    if (!pin_dclo_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      adr_q    <= 16'd0;
      wdat_q   <= 16'd0;
      we_q     <= 1'b0;
      bt_q     <= 1'b0;
      rdat_q   <= 16'd0;
      rply_m_q <= 1'b1;
      rply_s_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      we_q     <= we_d;
      bt_q     <= bt_d;
      rdat_q   <= rdat_d;
      rply_m_q <= pin_rply_n;
      rply_s_q <= rply_m_q;
    end
  end

  // Next state; the timeout counter restarts on entry to both wait phases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    we_d    = we_q;
    bt_d    = bt_q;
    rdat_d  = rdat_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          adr_d   = adr;
          wdat_d  = wdat;
          we_d    = we;
          bt_d    = bt;
          state_d = S_ADR;
        end
      end
      S_ADR: state_d = S_SYN;
      S_SYN: state_d = S_DAT;
      S_DAT: begin
        cnt_d   = 8'd0;
        state_d = S_STB;
      end
      S_STB: begin
        if (!rply_s_q) begin
          if (!we_q) rdat_d = ~pin_ad_in_n;
          cnt_d   = 8'd0;
          state_d = S_REL;
        end else if (cnt_q == TOUT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_REL: begin
        if (rply_s_q) begin
          state_d = S_FIN;
        end else if (cnt_q == TOUT_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pin decode: address phase drives ~adr, write data phases drive ~wdat.
  always_comb begin
    pin_sync_n   = 1'b1;
    pin_din_n    = 1'b1;
    pin_dout_n   = 1'b1;
    pin_wtbt_n   = 1'b1;
    pin_ad_oe    = 1'b0;
    pin_ad_out_n = 16'hFFFF;
    ack          = 1'b0;
    err          = 1'b0;
    case (state_q)
      S_ADR, S_SYN: begin
        pin_sync_n   = (state_q == S_ADR);
        pin_ad_oe    = 1'b1;
        pin_ad_out_n = ~adr_q;
        pin_wtbt_n   = ~we_q;
      end
      S_DAT, S_STB, S_REL: begin
        pin_sync_n = 1'b0;
        if (we_q) begin
          pin_ad_oe    = 1'b1;
          pin_ad_out_n = ~wdat_q;
          pin_wtbt_n   = ~bt_q;
          pin_dout_n   = (state_q != S_STB);
        end else begin
          pin_din_n = (state_q == S_REL);
        end
      end
      S_FIN:   ack = 1'b1;
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

  assign rdat        = rdat_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_qbus_master.sv
// Bench for qbus_master: an RPLY responder, a per-state pin snapshot monitor,
// and per-scenario tasks that check completions against an expected queue.
module tb_qbus_master;
  localparam int TOUT = 64;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_ADR = 3'd1, ST_SYN = 3'd2, ST_DAT = 3'd3,
                         ST_STB = 3'd4, ST_REL = 3'd5, ST_FIN = 3'd6, ST_ERR = 3'd7;

  logic        clk = 1'b0;
  logic        dclo_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, bt = 1'b0;
  logic [15:0] adr = 16'd0, wdat = 16'd0;
  logic [15:0] ad_in_n = 16'hFFFF;
  logic        rply_n = 1'b1;
  logic [15:0] rdat, ad_out_n;
  logic        ack, err, busy, ad_oe, sync_n, din_n, dout_n, wtbt_n;
  logic [2:0]  dbg_state;

  qbus_master #(.TOUT(TOUT)) dut (
    .pin_clk_p(clk), .pin_dclo_n(dclo_n), .req(req), .we(we), .bt(bt),
    .adr(adr), .wdat(wdat), .rdat(rdat), .ack(ack), .err(err), .busy(busy),
    .pin_ad_in_n(ad_in_n), .pin_ad_out_n(ad_out_n), .pin_ad_oe(ad_oe),
    .pin_sync_n(sync_n), .pin_din_n(din_n), .pin_dout_n(dout_n),
    .pin_wtbt_n(wtbt_n), .pin_rply_n(rply_n), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];      // {err_pulse, rdat} expected at each completion
  logic [15:0] model_rdat = 16'd0;

  // Slave responder: asserts RPLY resp_delay cycles after DIN/DOUT, holds it
  // resp_hold cycles after the strobe is released.
  logic        resp_en = 1'b0;
  int          resp_delay = 3, resp_hold = 0;
  logic [15:0] resp_data = 16'd0;
  int          dcnt = 0, hcnt = 0;
  always @(negedge clk) begin
    if (!resp_en) begin
      rply_n = 1'b1; dcnt = 0; hcnt = 0;
    end else if (!din_n || !dout_n) begin
      hcnt = 0;
      if (dcnt >= resp_delay) begin
        rply_n = 1'b0; ad_in_n = ~resp_data;
      end else dcnt++;
    end else begin
      dcnt = 0;
      if (!rply_n) begin
        if (hcnt >= resp_hold) rply_n = 1'b1;
        else hcnt++;
      end
    end
  end

  // Monitor: state trace, last pin values seen per state, entry cycles.
  int cyc = 0, ack_cnt = 0, err_cnt = 0, overlap_cnt = 0;
  int stb_cyc = 0, rel_cyc = 0, err_cyc = 0, idle_run = 0, idle_gap = 0;
  logic [2:0]  prev_state = ST_IDLE;
  logic [2:0]  trace[$];
  logic [15:0] snap_ad[8];
  logic        snap_oe[8], snap_sync[8], snap_din[8], snap_dout[8], snap_wtbt[8];
  always @(negedge clk) begin
    cyc++;
    if (!din_n && !dout_n) overlap_cnt++;
    if (!sync_n && !din_n && !dout_n) overlap_cnt++;
    if (ack === 1'b1) ack_cnt++;
    if (err === 1'b1) begin err_cnt++; err_cyc = cyc; end
    snap_ad[dbg_state] = ad_out_n;  snap_oe[dbg_state] = ad_oe;
    snap_sync[dbg_state] = sync_n;  snap_din[dbg_state] = din_n;
    snap_dout[dbg_state] = dout_n;  snap_wtbt[dbg_state] = wtbt_n;
    if (dbg_state != prev_state) begin
      trace.push_back(dbg_state);
      if (dbg_state == ST_STB) stb_cyc = cyc;
      if (dbg_state == ST_REL) rel_cyc = cyc;
      if (dbg_state == ST_ADR) idle_gap = idle_run;
    end
    idle_run = (dbg_state == ST_IDLE) ? idle_run + 1 : 0;
    prev_state = dbg_state;
  end

  task automatic start_txn(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    we = w; bt = b; adr = a; wdat = d; req = 1'b1;
    trace.delete();
  endtask

  // Waits for ack/err, drops req, pops and compares the expected completion.
  task automatic finish_txn(input string name);
    logic [16:0] exp;
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk); #1;
      if (ack === 1'b1 || err === 1'b1) done = 1;
    end
    req = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: no ack/err within 400 cycles", name);
      void'(exp_q.pop_front());
    end else begin
      exp = exp_q.pop_front();
      if ({err, rdat} !== exp) begin
        errors++;
        $display("FAIL %s: {err,rdat} got %b/%o expected %b/%o", name, err, rdat, exp[16], exp[15:0]);
      end
    end
  endtask

  task automatic test_reset();
    dclo_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({sync_n, din_n, dout_n, wtbt_n, ad_oe} !== 5'b11110) begin
      errors++; $display("FAIL reset_strobes: got %b expected 11110", {sync_n, din_n, dout_n, wtbt_n, ad_oe});
    end
    checks++;
    if (ad_out_n !== 16'hFFFF) begin errors++; $display("FAIL reset_ad: got %h expected ffff", ad_out_n); end
    checks++;
    if ({ack, err, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {ack, err, busy}); end
    checks++;
    if (rdat !== 16'd0) begin errors++; $display("FAIL reset_rdat: got %h expected 0000", rdat); end
    checks++;
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    dclo_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read();
    int a0;
    logic [2:0] exp_tr[6];
    exp_tr = '{ST_ADR, ST_SYN, ST_DAT, ST_STB, ST_REL, ST_FIN};
    resp_en = 1'b1; resp_delay = 3; resp_hold = 0; resp_data = 16'o012345;
    a0 = ack_cnt;
    exp_q.push_back({1'b0, 16'o012345}); model_rdat = 16'o012345;
    start_txn(1'b0, 1'b0, 16'o001000, 16'd0);
    finish_txn("read_data");
    checks++;
    if (trace.size() < 6) begin errors++; $display("FAIL read_trace_len: got %0d expected >=6", trace.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++;
      if (trace[i] !== exp_tr[i]) begin errors++; $display("FAIL read_trace[%0d]: got %0d expected %0d", i, trace[i], exp_tr[i]); end
    end
    checks++;
    if (snap_ad[ST_ADR] !== ~16'o001000) begin errors++; $display("FAIL read_adr_drive: got %h expected %h", snap_ad[ST_ADR], ~16'o001000); end
    checks++;
    if ({snap_oe[ST_STB], snap_din[ST_STB], snap_wtbt[ST_DAT]} !== 3'b001) begin
      errors++; $display("FAIL read_dphase: oe/din/wtbt got %b expected 001", {snap_oe[ST_STB], snap_din[ST_STB], snap_wtbt[ST_DAT]});
    end
    repeat (3) @(negedge clk); #1;
    checks++;
    if (ack_cnt - a0 !== 1) begin errors++; $display("FAIL read_ack_count: got %0d expected 1", ack_cnt - a0); end
    checks++;
    if (rdat !== 16'o012345) begin errors++; $display("FAIL read_rdat_hold: got %o expected 012345", rdat); end
  endtask

  task automatic test_write(input logic b, input logic [15:0] a, input logic [15:0] d, input string name);
    resp_en = 1'b1; resp_delay = 2; resp_hold = 1;
    exp_q.push_back({1'b0, model_rdat});
    start_txn(1'b1, b, a, d);
    finish_txn(name);
    checks++;
    if (snap_ad[ST_ADR] !== ~a || snap_ad[ST_SYN] !== ~a) begin
      errors++; $display("FAIL %s_adr: got %h/%h expected %h", name, snap_ad[ST_ADR], snap_ad[ST_SYN], ~a);
    end
    checks++;
    if ({snap_wtbt[ST_ADR], snap_wtbt[ST_SYN], snap_sync[ST_ADR], snap_sync[ST_SYN]} !== 4'b0010) begin
      errors++; $display("FAIL %s_aphase: wtbt/sync got %b expected 0010", name, {snap_wtbt[ST_ADR], snap_wtbt[ST_SYN], snap_sync[ST_ADR], snap_sync[ST_SYN]});
    end
    checks++;
    if (snap_ad[ST_DAT] !== ~d || snap_wtbt[ST_DAT] !== ~b) begin
      errors++; $display("FAIL %s_dphase: ad/wtbt got %h/%b expected %h/%b", name, snap_ad[ST_DAT], snap_wtbt[ST_DAT], ~d, ~b);
    end
    checks++;
    if ({snap_dout[ST_DAT], snap_dout[ST_STB], snap_dout[ST_REL], snap_oe[ST_REL]} !== 4'b1011) begin
      errors++; $display("FAIL %s_dout: dat/stb/rel/oe got %b expected 1011", name, {snap_dout[ST_DAT], snap_dout[ST_STB], snap_dout[ST_REL], snap_oe[ST_REL]});
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    int a0;
    resp_en = 1'b0;
    a0 = ack_cnt;
    exp_q.push_back({1'b1, model_rdat});
    start_txn(1'b0, 1'b0, 16'o000200, 16'd0);
    finish_txn("tout_err");
    checks++;
    if (err_cyc - stb_cyc !== TOUT) begin errors++; $display("FAIL tout_latency: got %0d expected %0d", err_cyc - stb_cyc, TOUT); end
    checks++;
    if ({sync_n, din_n, dout_n, wtbt_n, ad_oe} !== 5'b11110) begin
      errors++; $display("FAIL tout_pins: got %b expected 11110", {sync_n, din_n, dout_n, wtbt_n, ad_oe});
    end
    @(negedge clk); #1;
    checks++;
    if ({err, ack_cnt - a0 == 0} !== 2'b01) begin errors++; $display("FAIL tout_pulse: err=%b acks=%0d expected 0/0", err, ack_cnt - a0); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rel_timeout();
    resp_en = 1'b1; resp_delay = 1; resp_hold = 70; resp_data = 16'o007070;
    exp_q.push_back({1'b1, 16'o007070}); model_rdat = 16'o007070;
    start_txn(1'b0, 1'b0, 16'o000400, 16'd0);
    finish_txn("rel_err");
    checks++;
    if (err_cyc - rel_cyc !== TOUT) begin errors++; $display("FAIL rel_latency: got %0d expected %0d", err_cyc - rel_cyc, TOUT); end
    repeat (12) @(negedge clk);
    resp_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int a0, e0;
    bit hit = 0;
    resp_en = 1'b0;
    a0 = ack_cnt; e0 = err_cnt;
    start_txn(1'b0, 1'b0, 16'o000600, 16'd0);
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk); #1;
      if (dbg_state === ST_STB) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL mid_reach_stb: state %0d expected 4", dbg_state); end
    req = 1'b0; dclo_n = 1'b0;
    @(negedge clk); #1;
    dclo_n = 1'b1; model_rdat = 16'd0;
    checks++;
    if ({busy, sync_n, din_n, dout_n, ad_oe, rdat} !== {5'b01110, 16'd0}) begin
      errors++; $display("FAIL mid_reset_out: busy/sync/din/dout/oe/rdat got %b/%h expected 01110/0000", {busy, sync_n, din_n, dout_n, ad_oe}, rdat);
    end
    repeat (5) @(negedge clk); #1;
    checks++;
    if (ack_cnt !== a0 || err_cnt !== e0) begin errors++; $display("FAIL mid_no_pulse: acks+%0d errs+%0d expected 0/0", ack_cnt - a0, err_cnt - e0); end
    resp_en = 1'b1; resp_delay = 2; resp_hold = 0; resp_data = 16'o123456;
    exp_q.push_back({1'b0, 16'o123456}); model_rdat = 16'o123456;
    start_txn(1'b0, 1'b0, 16'o000010, 16'd0);
    finish_txn("mid_next_read");
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int a0;
    bit done;
    resp_en = 1'b1; resp_delay = 1; resp_hold = 0;
    a0 = ack_cnt;
    exp_q.push_back({1'b0, model_rdat});
    exp_q.push_back({1'b0, model_rdat});
    start_txn(1'b1, 1'b0, 16'o000020, 16'o000777);
    for (int n = 0; n < 2; n++) begin
      logic [16:0] exp;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
        @(negedge clk); #1;
        if (ack === 1'b1) done = 1;
      end
      if (n == 1) req = 1'b0;
      exp = exp_q.pop_front();
      checks++;
      if (!done) begin errors++; $display("FAIL b2b_ack%0d: no ack within 200 cycles", n); end
      else if ({err, rdat} !== exp) begin
        errors++; $display("FAIL b2b_ack%0d: {err,rdat} got %b/%o expected %b/%o", n, err, rdat, exp[16], exp[15:0]);
      end
    end
    req = 1'b0;
    repeat (4) @(negedge clk); #1;
    checks++;
    if (ack_cnt - a0 !== 2) begin errors++; $display("FAIL b2b_ack_count: got %0d expected 2", ack_cnt - a0); end
    checks++;
    if (idle_gap !== 1 || snap_sync[ST_IDLE] !== 1'b1) begin
      errors++; $display("FAIL b2b_gap: idle cycles %0d sync_n %b expected 1/1", idle_gap, snap_sync[ST_IDLE]);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (overlap_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d expected 0", overlap_cnt); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write(1'b0, 16'o177566, 16'o000101, "word_write");
    test_write(1'b1, 16'o000003, 16'o052000, "byte_write");
    test_timeout();
    test_rel_timeout();
    test_reset_mid();
    test_back_to_back();
    test_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
